fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard-control unit for the pipelined TSC core. It supersedes the fixed two-source, 2-bit forwarding logic. It compares decode-stage source registers against in-flight destinations and registers per-source forwarding selects for the EX stage. It also detects load-use hazards and sequences multi-cycle stalls and control-redirect flushes through a small FSM, and keeps a saturating stall-cycle performance counter.

Parameters:
REG_AW, 2, register address width (4 GPRs).
NUM_SRC, 2, number of source operands compared per instruction.
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (>=1).
FLUSH_CYCLES, 1, cycles IF/ID is flushed after a redirect (>=1).
CNT_W, 16, width of the stall performance counter.

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  NUM_SRC*REG_AW  source regs; src i at [i*REG_AW +: REG_AW]
id_rs_used  in  NUM_SRC  src i is actually read by the instruction
ex_rd  in  REG_AW  destination of the instruction in EX
ex_reg_write  in  1  EX instruction writes the register file
ex_mem_read  in  1  EX instruction is a load (LWD)
exmem_rd  in  REG_AW  destination in EX/MEM
exmem_reg_write  in  1  EX/MEM writes the register file
redirect  in  1  taken branch or jump resolved this cycle
fwd_sel  out  2*NUM_SRC  registered select per src: 0 regfile, 1 MEM/WB, 2 EX/MEM
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID
bubble_idex  out  1  load NOP into ID/EX
flush_ifid  out  1  clear IF/ID to NOP
stall_count  out  CNT_W  total cycles with stall_pc=1, saturating

Behaviour:
- Reset: fwd_sel=0, FSM=IDLE, remaining-count=0, stall_count=0. All combinational stall and flush outputs are 0 while reset=1.
- No zero register exists: rd==0 matches like any other index.
- Src i is live only when id_valid & id_rs_used[i].
- Load-use hazard (haz): any live src i with ex_reg_write & ex_mem_read & ex_rd==rs_i.
- Forward next-select per src i:
  - 2 if live & ex_reg_write & !ex_mem_read & ex_rd==rs_i.
  - Else 1 if live & exmem_reg_write & exmem_rd==rs_i.
  - Else 0.
  - EX match takes priority over EX/MEM match.
- fwd_sel is registered at posedge and consumed by EX in the following cycle, so it has 1-cycle latency.
- fwd_sel loads all zeros whenever bubble_idex=1 in the current cycle.
- The register file write-before-read bypass is outside this block.
- FSM states:
  - IDLE:
    - If redirect: flush_ifid=1 and bubble_idex=1 this cycle. If FLUSH_CYCLES>1, go to FLUSH with rem=FLUSH_CYCLES-1.
    - Else if haz: stall_pc=1, stall_ifid=1, bubble_idex=1 this cycle. If LOAD_STALL_CYCLES>1, go to LSTALL with rem=LOAD_STALL_CYCLES-1.
  - LSTALL: stall_pc=1, stall_ifid=1, bubble_idex=1. Decrement rem; at rem==1 return to IDLE. A redirect in LSTALL aborts the stall and behaves exactly as redirect in IDLE (stall outputs 0 that cycle).
  - FLUSH: flush_ifid=1, bubble_idex=1. Decrement rem; at rem==1 return to IDLE. A redirect in FLUSH reloads rem=FLUSH_CYCLES-1, or returns to IDLE if FLUSH_CYCLES==1.
- Priority: redirect > load-use > forwarding.
- stall_pc and stall_ifid are never 1 in a cycle where flush_ifid=1.
- stall_count increments on every cycle where stall_pc=1 and holds at all-ones.
- Reset mid-stall or mid-flush: returns to IDLE next edge, and outputs drop immediately because they are gated by reset.

Test Plan:
1. Reset, then ADD r1 in EX (ex_rd=1, ex_reg_write=1) and ID reads r1 on src0 -> next cycle fwd_sel[1:0]=2, fwd_sel[3:2]=0, no stall.
2. exmem_rd=2 writing and ex_rd=2 writing while ID reads r2 on both srcs -> fwd_sel=4'b1010 (EX priority). Repeat with ex_reg_write=0 -> fwd_sel=4'b0101.
3. LWD r3 in EX and ID reads r3 on src1 -> stall_pc=stall_ifid=bubble_idex=1 for exactly 1 cycle, fwd_sel=0 next edge, stall_count=1. The following cycle with exmem_rd=3 -> fwd_sel[3:2]=1.
4. LOAD_STALL_CYCLES=3 with the same hazard -> 3 consecutive stall cycles, stall_count=3. Redirect on the 2nd cycle -> flush_ifid=1, stall_pc=0, FSM back to IDLE, stall_count=1.
5. FLUSH_CYCLES=2 and redirect pulse -> flush_ifid=1 for 2 cycles. A hazard present in the same first cycle -> no stall asserted.
6. Force 2^CNT_W+5 stall cycles (CNT_W=4 build) -> stall_count saturates at 4'hF. Assert reset during LSTALL -> all outputs 0 in that cycle, count 0 next edge.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select, load-use stall and redirect-flush
// sequencing for the pipelined TSC core, plus a saturating stall-cycle counter.
//
// Ports:
//   clk, reset                 core clock, synchronous active-high reset
//   id_valid, id_rs, id_rs_used  decode-stage instruction and its source regs
//   ex_rd, ex_reg_write, ex_mem_read   instruction currently in EX
//   exmem_rd, exmem_reg_write  instruction currently in EX/MEM
//   redirect                   taken branch/jump resolved this cycle
//   fwd_sel                    registered per-source select (0 RF, 1 MEM/WB, 2 EX/MEM)
//   stall_pc, stall_ifid       hold PC / IF/ID (combinational)
//   bubble_idex, flush_ifid    insert NOP into ID/EX / clear IF/ID (combinational)
//   stall_count                saturating count of cycles with stall_pc=1
module fwd_hazard_unit #(
  parameter int unsigned REG_AW            = 2,
  parameter int unsigned NUM_SRC           = 2,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic [REG_AW-1:0]         exmem_rd,
  input  logic                      exmem_reg_write,
  input  logic                      redirect,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_pc,
  output logic                      stall_ifid,
  output logic                      bubble_idex,
  output logic                      flush_ifid,
  output logic [CNT_W-1:0]          stall_count
);

  // Remaining-cycle counter only ever holds values up to max(LOAD, FLUSH) - 1.
  localparam int unsigned REM_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ?
                                    LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int unsigned REM_W   = (REM_MAX > 1) ? $clog2(REM_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [REM_W-1:0]     rem;
  logic [REM_W-1:0]     rem_nx;
  logic [NUM_SRC-1:0]   live;
  logic [NUM_SRC-1:0]   haz_vec;
  logic                 haz;
  logic [REG_AW-1:0]    rs;
  logic [2*NUM_SRC-1:0] fwd_nx;

  // Per-source comparison: load-use detection and next forwarding select.
  always_comb begin
    live    = '0;
    haz_vec = '0;
    fwd_nx  = '0;
    rs      = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      rs         = id_rs[i*REG_AW +: REG_AW];
      live[i]    = id_valid & id_rs_used[i];
      haz_vec[i] = live[i] & ex_reg_write & ex_mem_read & (ex_rd == rs);
      // EX result is newer than EX/MEM, so it wins when both match.
      if (live[i] && ex_reg_write && !ex_mem_read && (ex_rd == rs)) begin
        fwd_nx[2*i +: 2] = 2'd2;
      end else if (live[i] && exmem_reg_write && (exmem_rd == rs)) begin
        fwd_nx[2*i +: 2] = 2'd1;
      end
    end
    haz = |haz_vec;
  end

  // Next-state and control outputs; everything stays low while reset is high.
  always_comb begin
    state_nx    = state;
    rem_nx      = rem;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    if (!reset) begin
      if (redirect) begin
        // Redirect overrides any stall or flush in progress from every state.
        flush_ifid  = 1'b1;
        bubble_idex = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nx = FLUSH;
          rem_nx   = REM_W'(FLUSH_CYCLES - 1);
        end else begin
          state_nx = IDLE;
          rem_nx   = '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (haz) begin
              stall_pc    = 1'b1;
              stall_ifid  = 1'b1;
              bubble_idex = 1'b1;
              if (LOAD_STALL_CYCLES > 1) begin
                state_nx = LSTALL;
                rem_nx   = REM_W'(LOAD_STALL_CYCLES - 1);
              end
            end
          end
          LSTALL: begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
            if (rem == REM_W'(1)) begin
              state_nx = IDLE;
              rem_nx   = '0;
            end else begin
              rem_nx = rem - REM_W'(1);
            end
          end
          FLUSH: begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            if (rem == REM_W'(1)) begin
              state_nx = IDLE;
              rem_nx   = '0;
            end else begin
              rem_nx = rem - REM_W'(1);
            end
          end
          default: begin
            state_nx = IDLE;
            rem_nx   = '0;
          end
        endcase
      end
    end
  end

  // State, forwarding-select and performance-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= '0;
      fwd_sel     <= '0;
      stall_count <= '0;
    end else begin
      state   <= state_nx;
      rem     <= rem_nx;
      // A bubbled ID/EX slot carries no operands, so nothing is forwarded.
      fwd_sel <= bubble_idex ? '0 : fwd_nx;
      if (stall_pc && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench for fwd_hazard_unit. A driver applies
// directed and random vectors on the falling edge and pushes the reference
// model's expectation; a monitor pops and checks each cycle's outputs.
module tb_fwd_hazard_unit;

  localparam int unsigned AW = 2;
  localparam int unsigned NS = 2;
  localparam int unsigned LC = 3;
  localparam int unsigned FC = 2;
  localparam int unsigned CW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [NS*AW-1:0] id_rs;
  logic [NS-1:0]   id_rs_used;
  logic [AW-1:0]   ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [AW-1:0]   exmem_rd;
  logic            exmem_reg_write;
  logic            redirect;
  logic [2*NS-1:0] fwd_sel;
  logic            stall_pc;
  logic            stall_ifid;
  logic            bubble_idex;
  logic            flush_ifid;
  logic [CW-1:0]   stall_count;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .REG_AW(AW), .NUM_SRC(NS), .LOAD_STALL_CYCLES(LC),
    .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .exmem_rd(exmem_rd),
    .exmem_reg_write(exmem_reg_write), .redirect(redirect),
    .fwd_sel(fwd_sel), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
    .stall_count(stall_count)
  );

  typedef struct packed {
    logic            stall_pc;
    logic            stall_ifid;
    logic            bubble_idex;
    logic            flush_ifid;
    logic [2*NS-1:0] fwd;
    logic [CW-1:0]   cnt;
  } exp_t;

  exp_t sb_q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model state: plain remaining-cycle counts and an integer counter.
  int m_stall_left = 0;
  int m_flush_left = 0;
  int m_cnt        = 0;

  task automatic drive(input logic r, input logic v, input logic [3:0] rs,
                       input logic [1:0] used, input logic [1:0] exrd,
                       input logic exw, input logic exm, input logic [1:0] emrd,
                       input logic emw, input logic redir);
    exp_t e;
    int   sel [NS];
    int   rsi;
    bit   haz;
    bit   live;
    @(negedge clk);
    reset = r; id_valid = v; id_rs = rs; id_rs_used = used; ex_rd = exrd;
    ex_reg_write = exw; ex_mem_read = exm; exmem_rd = emrd;
    exmem_reg_write = emw; redirect = redir;
    haz = 0;
    for (int i = 0; i < int'(NS); i++) begin
      rsi  = (int'(rs) >> (2 * i)) & 3;
      live = v && used[i];
      if (live && exw && exm && int'(exrd) == rsi) haz = 1;
      if (live && exw && !exm && int'(exrd) == rsi) sel[i] = 2;
      else if (live && emw && int'(emrd) == rsi)    sel[i] = 1;
      else                                          sel[i] = 0;
    end
    e = '0;
    if (r) begin
      m_stall_left = 0;
      m_flush_left = 0;
      m_cnt        = 0;
    end else begin
      if (redir) begin
        e.flush_ifid = 1; e.bubble_idex = 1;
        m_flush_left = FC - 1;
        m_stall_left = 0;
      end else if (m_flush_left > 0) begin
        e.flush_ifid = 1; e.bubble_idex = 1;
        m_flush_left--;
      end else if (m_stall_left > 0) begin
        e.stall_pc = 1; e.stall_ifid = 1; e.bubble_idex = 1;
        m_stall_left--;
      end else if (haz) begin
        e.stall_pc = 1; e.stall_ifid = 1; e.bubble_idex = 1;
        m_stall_left = LC - 1;
      end
      if (e.stall_pc && m_cnt < (1 << CW) - 1) m_cnt++;
      if (!e.bubble_idex) begin
        for (int i = 0; i < int'(NS); i++) e.fwd[2*i +: 2] = 2'(sel[i]);
      end
    end
    e.cnt = CW'(m_cnt);
    sb_q.push_back(e);
  endtask

  task automatic idle_cycle();
    drive(0, 0, 4'h0, 2'b00, 2'd0, 0, 0, 2'd0, 0, 0);
  endtask

  // Monitor: control outputs sampled mid-cycle, registers just after the edge.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = '0;
        g.stall_pc    = stall_pc;
        g.stall_ifid  = stall_ifid;
        g.bubble_idex = bubble_idex;
        g.flush_ifid  = flush_ifid;
        @(posedge clk);
        #1;
        g.fwd = fwd_sel;
        g.cnt = stall_count;
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL vec%0d: got stall_pc=%b stall_ifid=%b bubble=%b flush=%b fwd_sel=%b stall_count=%0d, expected stall_pc=%b stall_ifid=%b bubble=%b flush=%b fwd_sel=%b stall_count=%0d",
                   vectors, g.stall_pc, g.stall_ifid, g.bubble_idex, g.flush_ifid,
                   g.fwd, g.cnt, e.stall_pc, e.stall_ifid, e.bubble_idex,
                   e.flush_ifid, e.fwd, e.cnt);
        end
      end
    end
  end

  initial begin
    logic r;
    logic redir;
    reset = 1; id_valid = 0; id_rs = '0; id_rs_used = '0; ex_rd = '0;
    ex_reg_write = 0; ex_mem_read = 0; exmem_rd = '0; exmem_reg_write = 0;
    redirect = 0;

    repeat (3) drive(1, 0, 4'h0, 2'b00, 2'd0, 0, 0, 2'd0, 0, 0);

    // EX forward on src0 only.
    drive(0, 1, {2'd0, 2'd1}, 2'b01, 2'd1, 1, 0, 2'd0, 0, 0);
    // Both sources match EX and EX/MEM: EX wins; then EX/MEM only.
    drive(0, 1, {2'd2, 2'd2}, 2'b11, 2'd2, 1, 0, 2'd2, 1, 0);
    drive(0, 1, {2'd2, 2'd2}, 2'b11, 2'd2, 0, 0, 2'd2, 1, 0);
    // Register 0 matches like any other index; unused source never forwards.
    drive(0, 1, {2'd0, 2'd0}, 2'b10, 2'd0, 1, 0, 2'd0, 1, 0);
    // Load-use on src1: multi-cycle stall, then EX/MEM forward.
    drive(0, 1, {2'd3, 2'd0}, 2'b10, 2'd3, 1, 1, 2'd0, 0, 0);
    drive(0, 1, {2'd3, 2'd0}, 2'b10, 2'd0, 0, 0, 2'd0, 0, 0);
    drive(0, 1, {2'd3, 2'd0}, 2'b10, 2'd0, 0, 0, 2'd0, 0, 0);
    drive(0, 1, {2'd3, 2'd0}, 2'b10, 2'd0, 0, 0, 2'd3, 1, 0);
    // Redirect on the second stall cycle aborts the stall.
    drive(0, 1, {2'd1, 2'd1}, 2'b01, 2'd1, 1, 1, 2'd0, 0, 0);
    drive(0, 1, {2'd1, 2'd1}, 2'b01, 2'd1, 1, 1, 2'd0, 0, 1);
    drive(0, 1, {2'd1, 2'd1}, 2'b01, 2'd1, 1, 1, 2'd0, 0, 0);
    idle_cycle();
    // Redirect with a simultaneous hazard: flush only.
    drive(0, 1, {2'd2, 2'd2}, 2'b11, 2'd2, 1, 1, 2'd0, 0, 1);
    drive(0, 1, {2'd2, 2'd2}, 2'b11, 2'd2, 1, 1, 2'd0, 0, 0);
    idle_cycle();
    // Persistent hazard long enough to saturate the counter.
    repeat (80) drive(0, 1, {2'd1, 2'd3}, 2'b11, 2'd3, 1, 1, 2'd0, 0, 0);
    // Reset in the middle of a load stall.
    idle_cycle();
    drive(0, 1, {2'd1, 2'd3}, 2'b01, 2'd3, 1, 1, 2'd0, 0, 0);
    drive(1, 1, {2'd1, 2'd3}, 2'b01, 2'd3, 1, 1, 2'd0, 0, 0);
    idle_cycle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      r     = ($urandom_range(0, 299) == 0);
      redir = ($urandom_range(0, 9) == 0);
      drive(r, 1'($urandom_range(0, 7) != 0), 4'($urandom), 2'($urandom),
            2'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
            2'($urandom), 1'($urandom), redir);
    end

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0",
               sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
